rst_seq: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 15 +
 rtl/rst_sync.sv | 33 +++
 rtl/rst_seq.sv | 161 ++++++++++++++++
 tb/tb_rst_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
//   rst_seq_state_e : sequencer FSM state encoding
//   RST_SYNC_STAGES : flop depth of the reset-input synchronizer
package rst_seq_pkg;

  localparam int unsigned RST_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_RESET      = 2'd0,
    ST_RELEASE    = 2'd1,
    ST_RUN        = 2'd2,
    ST_SWRST_HOLD = 2'd3
  } rst_seq_state_e;

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asynchronous assert, synchronous deassert.
// Reusable for any clock domain.
//   clk        : destination clock
//   rst_n      : asynchronous active-low reset in
//   rst_sync_n : active-low reset, deasserted STAGES edges after rst_n rises
module rst_sync
  import rst_seq_pkg::*;
#(
  parameter int unsigned STAGES = RST_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  if (STAGES < 2) begin : g_bad_stages
    $error("rst_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  // Shift ones in from bit 0; the top flop is the synchronized reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= STAGES'({sync_q, 1'b1});
    end
  end

  assign rst_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer. Releases NUM_STAGES_p active-low resets in order
// (bit 0 first), STAGE_DELAY_p cycles apart, after the system reset has been
// synchronized. A software reset request in RUN re-asserts all stages, holds
// them for SWRST_HOLD_p cycles and replays the release sequence.
// Build option: define RST_SEQ_SWRST_EN to enable the software reset path;
// without it i_swrst_req is ignored and o_swrst_busy is tied low.
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low system reset
//   i_swrst_req  : single-cycle software reset request
//   o_rst_n      : staged active-low resets
//   o_rst_done   : all stages released
//   o_swrst_busy : software reset in progress
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES_p  = 3,
  parameter int unsigned STAGE_DELAY_p = 16,
  parameter int unsigned SWRST_HOLD_p  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_swrst_req,
  output logic [NUM_STAGES_p-1:0] o_rst_n,
  output logic                    o_rst_done,
  output logic                    o_swrst_busy
);

  localparam int unsigned CNT_MAX = (STAGE_DELAY_p > SWRST_HOLD_p) ? STAGE_DELAY_p : SWRST_HOLD_p;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = (NUM_STAGES_p > 1) ? $clog2(NUM_STAGES_p) : 1;

  if (NUM_STAGES_p == 0 || NUM_STAGES_p > 8) begin : g_bad_num_stages
    $error("rst_seq: NUM_STAGES_p must be in 1..8");
  end
  if (STAGE_DELAY_p == 0) begin : g_bad_stage_delay
    $error("rst_seq: STAGE_DELAY_p must be at least 1");
  end
  if (SWRST_HOLD_p == 0) begin : g_bad_swrst_hold
    $error("rst_seq: SWRST_HOLD_p must be at least 1");
  end

  logic rst_sync_n;

  rst_sync #(
    .STAGES(RST_SYNC_STAGES)
  ) u_rst_sync (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .rst_sync_n(rst_sync_n)
  );

  rst_seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES_p-1:0] stage_q, stage_d;
  logic                    done_q, done_d;
`ifdef RST_SEQ_SWRST_EN
  logic                    busy_q, busy_d;
`endif

  // State register; rst_sync_n follows i_rst_n low asynchronously.
  always_ff @(posedge i_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
`ifdef RST_SEQ_SWRST_EN
      busy_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
`ifdef RST_SEQ_SWRST_EN
      busy_q  <= busy_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
`ifdef RST_SEQ_SWRST_EN
    busy_d  = busy_q;
`endif
    case (state_q)
      ST_RESET: begin
        state_d = ST_RELEASE;
        cnt_d   = '0;
        idx_d   = '0;
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_W'(STAGE_DELAY_p - 1)) begin
          cnt_d   = '0;
          // Stages release in order, so shifting a one in releases stage idx.
          stage_d = NUM_STAGES_p'({stage_q, 1'b1});
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_STAGES_p - 1)) begin
            state_d = ST_RUN;
            idx_d   = '0;
            done_d  = 1'b1;
`ifdef RST_SEQ_SWRST_EN
            busy_d  = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
`ifdef RST_SEQ_SWRST_EN
        if (i_swrst_req) begin
          state_d = ST_SWRST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          stage_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
`endif
      end
`ifdef RST_SEQ_SWRST_EN
      ST_SWRST_HOLD: begin
        if (cnt_q == CNT_W'(SWRST_HOLD_p - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign o_rst_n    = stage_q;
  assign o_rst_done = done_q;

`ifdef RST_SEQ_SWRST_EN
  assign o_swrst_busy = busy_q;
`else
  logic unused_swrst_req;
  assign unused_swrst_req = i_swrst_req;
  assign o_swrst_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq (NUM_STAGES_p=3, STAGE_DELAY_p=4,
// SWRST_HOLD_p=8). Expected outputs come from a timeline model: each stage's
// release edge is an arithmetic function of the sequence origin.
module tb_rst_seq;

  localparam int NS = 3;
  localparam int SD = 4;
  localparam int SH = 8;
`ifdef RST_SEQ_SWRST_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          req   = 1'b0;
  logic [NS-1:0] o_rst_n;
  logic          o_done;
  logic          o_busy;

  always #5 clk = ~clk;

  rst_seq #(
    .NUM_STAGES_p (NS),
    .STAGE_DELAY_p(SD),
    .SWRST_HOLD_p (SH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_swrst_req (req),
    .o_rst_n     (o_rst_n),
    .o_rst_done  (o_done),
    .o_swrst_busy(o_busy)
  );

  int errors = 0;
  int checks = 0;

  // Timeline model: edge 0 is the first edge sampling i_rst_n high.
  bit in_reset = 1'b1;
  int cyc      = 0;
  int origin   = 2;
  bit sw       = 1'b0;

  function automatic logic [NS-1:0] m_rst(int c);
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) r[k] = (c >= origin + (k + 1) * SD);
    return r;
  endfunction

  function automatic bit m_done(int c);
    return c >= origin + NS * SD;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic check_model();
    logic [NS-1:0] er;
    logic ed, eb;
    if (in_reset) begin
      er = '0; ed = 1'b0; eb = 1'b0;
    end else begin
      er = m_rst(cyc);
      ed = m_done(cyc);
      eb = sw && !m_done(cyc);
    end
    check("model_rst_n", 32'(o_rst_n), 32'(er));
    check("model_done",  32'(o_done),  32'(ed));
    check("model_busy",  32'(o_busy),  32'(eb));
  endtask

  // Drive req for the next edge, advance the model at that edge, then sample.
  task automatic tick(bit r);
    req = r;
    @(posedge clk);
    if (rst_n) begin
      if (in_reset) begin
        in_reset = 1'b0;
        cyc      = 0;
        origin   = 2;
        sw       = 1'b0;
      end else begin
        if (SW_EN && r && m_done(cyc)) begin
          origin = cyc + 1 + SH;
          sw     = 1'b1;
        end
        cyc++;
      end
    end
    #1;
    req = 1'b0;
    check_model();
  endtask

  // Assert i_rst_n between edges; outputs must clear without a clock edge.
  task automatic async_reset(int hold, string name);
    rst_n = 1'b0;
    #1;
    in_reset = 1'b1;
    check({name, "_rst_n"}, 32'(o_rst_n), 32'(0));
    check({name, "_done"},  32'(o_done),  32'(0));
    check({name, "_busy"},  32'(o_busy),  32'(0));
    for (int i = 0; i < hold; i++) tick(1'b0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int            e;
    logic [NS-1:0] rst;
    logic          done;
    logic          busy;
  } vec_t;

  vec_t pon[8];
  vec_t swv[7];

  // Power-on table replay; optionally pulses req at edge 8 (RELEASE).
  task automatic run_power_on(bit req_at_8, string name);
    int j = 0;
    for (int i = 0; i <= 20; i++) begin
      tick(req_at_8 && i == 8);
      if (j < 8 && cyc == pon[j].e) begin
        check({name, "_tbl_rst_n"}, 32'(o_rst_n), 32'(pon[j].rst));
        check({name, "_tbl_done"},  32'(o_done),  32'(pon[j].done));
        check({name, "_tbl_busy"},  32'(o_busy),  32'(pon[j].busy));
        j++;
      end
    end
    check({name, "_tbl_all_hit"}, 32'(j), 32'(8));
  endtask

  initial begin
    pon[0] = '{e: 0,  rst: 3'b000, done: 1'b0, busy: 1'b0};
    pon[1] = '{e: 5,  rst: 3'b000, done: 1'b0, busy: 1'b0};
    pon[2] = '{e: 6,  rst: 3'b001, done: 1'b0, busy: 1'b0};
    pon[3] = '{e: 9,  rst: 3'b001, done: 1'b0, busy: 1'b0};
    pon[4] = '{e: 10, rst: 3'b011, done: 1'b0, busy: 1'b0};
    pon[5] = '{e: 13, rst: 3'b011, done: 1'b0, busy: 1'b0};
    pon[6] = '{e: 14, rst: 3'b111, done: 1'b1, busy: 1'b0};
    pon[7] = '{e: 20, rst: 3'b111, done: 1'b1, busy: 1'b0};

    swv[0] = '{e: 0,  rst: 3'b000, done: 1'b0, busy: 1'b1};
    swv[1] = '{e: 11, rst: 3'b000, done: 1'b0, busy: 1'b1};
    swv[2] = '{e: 12, rst: 3'b001, done: 1'b0, busy: 1'b1};
    swv[3] = '{e: 15, rst: 3'b001, done: 1'b0, busy: 1'b1};
    swv[4] = '{e: 16, rst: 3'b011, done: 1'b0, busy: 1'b1};
    swv[5] = '{e: 19, rst: 3'b011, done: 1'b0, busy: 1'b1};
    swv[6] = '{e: 20, rst: 3'b111, done: 1'b1, busy: 1'b0};

    // Reset state.
    #1;
    check("reset_rst_n", 32'(o_rst_n), 32'(0));
    check("reset_done",  32'(o_done),  32'(0));
    check("reset_busy",  32'(o_busy),  32'(0));
    for (int i = 0; i < 3; i++) tick(1'b0);
    rst_n = 1'b1;

    run_power_on(1'b0, "pon");

    // Software reset in RUN; E0 is the capture edge.
    begin
      int e0;
      int j = 0;
      tick(1'b1);
      e0 = cyc;
      for (int i = 0; i <= 22; i++) begin
        if (i > 0) tick(1'b0);
        if (j < 7 && cyc - e0 == swv[j].e) begin
          check("swrst_tbl_rst_n", 32'(o_rst_n), SW_EN ? 32'(swv[j].rst)  : 32'(3'b111));
          check("swrst_tbl_done",  32'(o_done),  SW_EN ? 32'(swv[j].done) : 32'(1));
          check("swrst_tbl_busy",  32'(o_busy),  SW_EN ? 32'(swv[j].busy) : 32'(0));
          j++;
        end
      end
      check("swrst_tbl_all_hit", 32'(j), 32'(7));
    end

    // Request during RELEASE is ignored.
    async_reset(2, "pre_rel");
    run_power_on(1'b1, "rel_req");

    // i_rst_n asserted at edge 11 of power-on, then a full replay.
    async_reset(2, "pre_mid");
    for (int i = 0; i <= 11; i++) tick(1'b0);
    check("mid_edge11_rst_n", 32'(o_rst_n), 32'(3'b011));
    async_reset(3, "mid_async");
    run_power_on(1'b0, "replay");

    // i_rst_n asserted during the software-reset hold.
    tick(1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0);
    async_reset(2, "hold_async");
    run_power_on(1'b0, "post_hold");

    // Randomized requests and occasional system resets against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset(int'($urandom_range(1, 3)), "rnd_async");
      end else begin
        tick($urandom_range(0, 14) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
